// File: rtl/udp_rx_payload_fifo_if.sv
// rtl/udp_rx_payload_fifo_if.sv - receive byte stream in, committed payload stream and counters out
// The slave modport is the payload FIFO; the master modport is the surrounding MAC/consumer side.
interface udp_rx_payload_fifo_if;
  logic        rx_frame;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        rx_frame_end;
  logic        rx_frame_ok;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;

  modport slave (
    input  rx_frame, rx_byte_valid, rx_byte, rx_frame_end, rx_frame_ok, out_ready,
    output out_valid, out_data, out_last, pkt_count, drop_count
  );

  modport master (
    output rx_frame, rx_byte_valid, rx_byte, rx_frame_end, rx_frame_ok, out_ready,
    input  out_valid, out_data, out_last, pkt_count, drop_count
  );
endinterface

// File: rtl/udp_rx_payload_fifo.sv
// rtl/udp_rx_payload_fifo.sv - UDP payload extractor with per-frame commit/rollback and FWFT readout
// Payload bytes are written tentatively at r_wr_tmp and only become visible once the frame commits.
module udp_rx_payload_fifo #(
  parameter int DEPTH_LOG2     = 9,
  parameter int LENQ_LOG2      = 2,
  parameter int PAYLOAD_OFFSET = 42
) (
  input  logic                 clkRx,
  input  logic                 rstn,
  udp_rx_payload_fifo_if.slave bus
);
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int QW = LENQ_LOG2 + 1;
  localparam logic [PW-1:0] BUF_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [QW-1:0] LQ_FULL     = {1'b1, {LENQ_LOG2{1'b0}}};
  localparam logic [10:0]   IDX_LEN_HI  = 11'd38;
  localparam logic [10:0]   IDX_LEN_LO  = 11'd39;
  localparam logic [10:0]   IDX_HDR_END = 11'(PAYLOAD_OFFSET - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_SKIP} state_t;
  state_t r_state, w_state_nxt;

  logic                 r_frame_d;
  logic [10:0]          r_byte_idx;
  logic [15:0]          r_udp_len, r_pay_cnt;
  logic                 r_ovf;
  logic [PW-1:0]        r_wr_tmp, r_wr_commit, r_rd_ptr, r_rem;
  logic [7:0]           r_mem [2**DEPTH_LOG2];
  logic [PW-1:0]        r_lenq [2**LENQ_LOG2];
  logic [QW-1:0]        r_lq_wr, r_lq_rd;
  logic                 r_out_valid;
  logic [7:0]           r_out_data;
  logic [15:0]          r_pkt_count;
  logic [7:0]           r_drop_count;

  logic [15:0]          w_pay_len, w_pay_cnt_nxt;
  logic [PW-1:0]        w_used, w_wr_tmp_nxt, w_rem_nxt, w_rd_ptr_nxt;
  logic [QW-1:0]        w_lq_cnt;
  logic [LENQ_LOG2-1:0] w_lq_nidx;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic w_lq_full, w_start, w_wr_en, w_commit, w_discard, w_ovf_nxt;
  logic w_hs, w_last, w_pop, w_load, w_valid_nxt;

  assign w_pay_len = r_udp_len - 16'd8;
  assign w_used    = r_wr_tmp - r_rd_ptr;
  assign w_lq_cnt  = r_lq_wr - r_lq_rd;
  assign w_lq_full = (w_lq_cnt == LQ_FULL);
  assign w_lq_nidx = r_lq_rd[LENQ_LOG2-1:0] + LENQ_LOG2'(1);
  assign w_hs      = r_out_valid & bus.out_ready;
  assign w_last    = (r_rem == PW'(1));
  assign w_rd_addr = w_rd_ptr_nxt[DEPTH_LOG2-1:0];

  always_ff @(posedge clkRx or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_frame_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame_d <= bus.rx_frame;
    end
  end

  // The byte in flight is accounted for before the end-of-frame commit decision.
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_wr_en       = 1'b0;
    w_commit      = 1'b0;
    w_discard     = 1'b0;
    w_pay_cnt_nxt = r_pay_cnt;
    w_ovf_nxt     = r_ovf;
    w_wr_tmp_nxt  = r_wr_tmp;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_frame && !r_frame_d) begin
          w_start     = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (bus.rx_byte_valid && r_byte_idx == IDX_HDR_END)
          w_state_nxt = (r_udp_len < 16'd9) ? S_SKIP : S_PAY;
      end
      S_PAY: begin
        if (bus.rx_byte_valid) begin
          if (w_used == BUF_FULL) begin
            w_ovf_nxt   = 1'b1;
            w_state_nxt = S_SKIP;
          end else begin
            w_wr_en       = 1'b1;
            w_wr_tmp_nxt  = r_wr_tmp + PW'(1);
            w_pay_cnt_nxt = r_pay_cnt + 16'd1;
            if (w_pay_cnt_nxt == w_pay_len)
              w_state_nxt = S_SKIP;
          end
        end
      end
      default: ;
    endcase
    if (r_state != S_IDLE) begin
      if (bus.rx_frame_end) begin
        if (bus.rx_frame_ok && !w_ovf_nxt && w_pay_cnt_nxt == w_pay_len &&
            w_pay_cnt_nxt != 16'd0 && !w_lq_full)
          w_commit = 1'b1;
        else
          w_discard = 1'b1;
        w_state_nxt = S_IDLE;
      end else if (!bus.rx_frame) begin
        w_discard   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clkRx or negedge rstn) begin
    if (!rstn) begin
      r_byte_idx   <= '0;
      r_udp_len    <= '0;
      r_pay_cnt    <= '0;
      r_ovf        <= 1'b0;
      r_wr_tmp     <= '0;
      r_wr_commit  <= '0;
      r_lq_wr      <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_start) begin
        r_byte_idx <= '0;
        r_wr_tmp   <= r_wr_commit;
        r_ovf      <= 1'b0;
        r_pay_cnt  <= '0;
      end else begin
        if (r_state == S_HDR && bus.rx_byte_valid) begin
          r_byte_idx <= r_byte_idx + 11'd1;
          if (r_byte_idx == IDX_LEN_HI) r_udp_len[15:8] <= bus.rx_byte;
          if (r_byte_idx == IDX_LEN_LO) r_udp_len[7:0]  <= bus.rx_byte;
        end
        r_pay_cnt <= w_pay_cnt_nxt;
        r_ovf     <= w_ovf_nxt;
        r_wr_tmp  <= w_discard ? r_wr_commit : w_wr_tmp_nxt;
      end
      if (w_commit) begin
        r_wr_commit <= w_wr_tmp_nxt;
        r_lq_wr     <= r_lq_wr + QW'(1);
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if (w_discard && r_drop_count != 8'hFF)
        r_drop_count <= r_drop_count + 8'd1;
    end
  end

  always_ff @(posedge clkRx) begin
    if (w_wr_en)  r_mem[r_wr_tmp[DEPTH_LOG2-1:0]] <= bus.rx_byte;
    if (w_commit) r_lenq[r_lq_wr[LENQ_LOG2-1:0]]  <= w_pay_cnt_nxt[PW-1:0];
  end

  // Output register is refilled from the next pointer so a held-ready consumer sees 1 byte/cycle.
  always_comb begin
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_valid_nxt  = r_out_valid;
    w_rem_nxt    = r_rem;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_hs) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      if (w_last) begin
        w_pop = 1'b1;
        if (w_lq_cnt > QW'(1)) begin
          w_load    = 1'b1;
          w_rem_nxt = r_lenq[w_lq_nidx];
        end else begin
          w_valid_nxt = 1'b0;
        end
      end else begin
        w_load    = 1'b1;
        w_rem_nxt = r_rem - PW'(1);
      end
    end else if (!r_out_valid && w_lq_cnt != '0) begin
      w_load      = 1'b1;
      w_valid_nxt = 1'b1;
      w_rem_nxt   = r_lenq[r_lq_rd[LENQ_LOG2-1:0]];
    end
  end

  always_ff @(posedge clkRx or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rem       <= '0;
      r_rd_ptr    <= '0;
      r_lq_rd     <= '0;
    end else begin
      r_out_valid <= w_valid_nxt;
      r_rem       <= w_rem_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      if (w_load) r_out_data <= r_mem[w_rd_addr];
      if (w_pop)  r_lq_rd <= r_lq_rd + QW'(1);
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_last   = r_out_valid & w_last;
  assign bus.pkt_count  = r_pkt_count;
  assign bus.drop_count = r_drop_count;
endmodule
